// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
// Purpose : constants shared by the interrupt controller, its bus interface
//           and the system bridge decoder.
// Contents: register byte offsets, CP0 HWInt vector width, default device
//           base address, and a helper that maps a bus offset to its
//           word-aligned register offset.
package irq_ctrl_pkg;

    localparam int          HWINT_W          = 6;

    localparam logic [3:0]  IRQ_MASK_OFF     = 4'h0;
    localparam logic [3:0]  IRQ_PEND_OFF     = 4'h4;
    localparam logic [3:0]  IRQ_MODE_OFF     = 4'h8;
    localparam logic [3:0]  IRQ_ID_OFF       = 4'hC;

    localparam logic [31:0] IRQ_DEFAULT_BASE = 32'h0000_7F20;

    // Byte lanes within a register are not decoded.
    function automatic logic [3:0] reg_offset(input logic [3:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if
// Purpose : system-bridge access port of the interrupt controller.
// Signals : sel   - address hit for this device
//           we    - write enable, qualified by sel
//           addr  - byte offset within the device (bits [1:0] ignored)
//           wdata - write data
//           rdata - read data, combinational from addr
// Modports: master (bridge side), slave (irq_ctrl side).
interface irq_ctrl_if;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, addr, wdata, input  rdata);
    modport slave  (input  sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Purpose : fixed-priority encoder for the ID register. Source 0 has the
//           highest priority.
// Ports   : vec - active (pending & mask) vector, N_SRC bits
//           id  - index+1 of the lowest set bit of vec, 0 when vec is empty
module irq_prio_enc #(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] vec,
    output logic [2:0]       id
);

    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) id = 3'(i + 1);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Purpose : interrupt controller between peripheral sources and CP0
//           HWInt[7:2]. Latches requests per source (edge or level mode),
//           masks them and drives a registered 6-bit hw_int vector.
// Ports   : clk     - system clock
//           reset   - synchronous, active-high
//           src_irq - raw sources, synchronous to clk
//           bus     - bridge access (irq_ctrl_if.slave)
//           hw_int  - registered masked pending vector; bits >= N_SRC are 0
//           irq_any - OR of hw_int
// Registers: 0x0 MASK (RW), 0x4 PENDING (R, write-1-to-clear),
//            0x8 MODE (RW, 1 = edge, 0 = level), 0xC ID (RO).
// Build option: define IRQ_STRETCH_EN to hold every hw_int bit for at least
//            STRETCH cycles after it asserts.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC   = 6,
    parameter int STRETCH = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_irq,
    irq_ctrl_if.slave          bus,
    output logic [HWINT_W-1:0] hw_int,
    output logic               irq_any
);

    if (N_SRC < 1 || N_SRC > HWINT_W || STRETCH < 1) begin : g_bad_param
        $error("irq_ctrl: N_SRC must be 1..6 and STRETCH >= 1");
    end

    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] hw_q;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] hw_next;
    logic [3:0]       offset;
    logic             wr;
    logic [2:0]       id;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:N_SRC]};

    assign offset = reg_offset(bus.addr);
    assign wr     = bus.sel & bus.we;
    assign active = pend_q & mask_q;
    assign rise   = src_irq & ~src_d;
    assign clr    = (wr && offset == IRQ_PEND_OFF) ? bus.wdata[N_SRC-1:0] : '0;

    // Edge bits: set beats a same-cycle clear. Level bits follow the source
    // directly, so a clear write cannot touch them.
    assign pend_next = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & src_irq);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            src_d  <= '0;
        end else begin
            if (wr && offset == IRQ_MASK_OFF) mask_q <= bus.wdata[N_SRC-1:0];
            if (wr && offset == IRQ_MODE_OFF) mode_q <= bus.wdata[N_SRC-1:0];
            pend_q <= pend_next;
            src_d  <= src_irq;
        end
    end

`ifdef IRQ_STRETCH_EN
    localparam int CW = $clog2(STRETCH + 1);

    logic [CW-1:0]    cnt [N_SRC];
    logic [N_SRC-1:0] active_d;
    logic [N_SRC-1:0] cnt_busy;

    // Reload on each rising edge of active; the load value of STRETCH-1 plus
    // the cycle driven by active itself gives STRETCH cycles of hw_int.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_d <= '0;
            for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
        end else begin
            active_d <= active;
            for (int i = 0; i < N_SRC; i++) begin
                if (active[i] && !active_d[i]) cnt[i] <= CW'(STRETCH - 1);
                else if (cnt[i] != '0)         cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        cnt_busy = '0;
        for (int i = 0; i < N_SRC; i++) cnt_busy[i] = (cnt[i] != '0);
    end

    assign hw_next = active | cnt_busy;
`else
    assign hw_next = active;
`endif

    always_ff @(posedge clk) begin
        if (reset) hw_q <= '0;
        else       hw_q <= hw_next;
    end

    assign hw_int  = HWINT_W'(hw_q);
    assign irq_any = |hw_q;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .vec (active),
        .id  (id)
    );

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (offset)
                IRQ_MASK_OFF: bus.rdata = 32'(mask_q);
                IRQ_PEND_OFF: bus.rdata = 32'(pend_q);
                IRQ_MODE_OFF: bus.rdata = 32'(mode_q);
                IRQ_ID_OFF:   bus.rdata = 32'(id);
                default:      bus.rdata = '0;
            endcase
        end
    end

endmodule
